memaccess_stage: RTL and testbench
==================================

Name: memaccess_stage

Overview:
- MEM (fourth) stage of the DLX pipeline. Consumes the EX-stage result bundle: ALU result/address, store data, instruction, memory write enable.
- Drives a req/ack data-memory port. Store data is placed on the correct byte lanes with byte enables; load data is extracted and sign- or zero-extended.
- Stalls upstream stages while an access is outstanding. Forwards results to write-back.

Parameters:
- TIMEOUT_CYCLES, 15: wait-state limit before an access is abandoned; used only with DMEM_TIMEOUT_EN.
- DATA_W, 32: datapath width; fixed at 32, no other value supported.

Ports:
- clock4  in  1  stage clock; all state updates on rising edge.
- reset4  in  1  synchronous, active-high reset.
- alu_in4  in  32  EX result; byte address for loads and stores.
- bin4  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- inst_in4  in  32  instruction; opcode = [31:26].
- mem_wr_en4  in  1  EX store qualifier.
- dmem_rdata  in  32  memory read word.
- dmem_ack  in  1  one-cycle completion pulse from memory.
- dmem_req  out  1  access request, registered.
- dmem_we  out  1  write strobe, registered.
- dmem_addr  out  32  word address = {alu[31:2],2'b00}.
- dmem_wdata  out  32  lane-shifted store data.
- dmem_be  out  4  byte enables.
- alu_out4  out  32  ALU result passed to WB.
- lmd_out4  out  32  extended load data.
- inst_out4  out  32  instruction passed to WB.
- stall4  out  1  combinational; holds IF/ID/EX.
- misalign_err  out  1  one-cycle pulse on a misaligned access.
- dmem_err  out  1  timeout pulse; exists only with DMEM_TIMEOUT_EN.

Behaviour:
- Reset (reset4 sampled high): every registered output is 0 and the FSM goes to IDLE. Reset overrides an in-flight access: dmem_req drops on that edge and the late ack is ignored.
- Opcode decode:
  - Loads: LB=000001, LBU=000010, LH=000011, LHU=000100, LW=000101.
  - Stores: SB=001000, SH=001001, SW=001010.
  - Every other opcode is a non-memory instruction.
- Alignment:
  - LH, LHU, SH require addr[0]=0.
  - LW, SW require addr[1:0]=00.
  - Misaligned access: no request is issued, misalign_err pulses, lmd_out4<=0, and the instruction is treated as a non-memory instruction. A store is therefore dropped.
- Lanes, little-endian:
  - SB: be=0001<<a[1:0]; wdata = bin4[7:0] replicated to all 4 bytes.
  - SH: be=0011<<{a[1],0}; wdata = bin4[15:0] replicated.
  - SW: be=1111; wdata = bin4.
  - Loads: be=1111.
- Load extraction: byte = rdata >> (8*a[1:0]); half = rdata >> (16*a[1]).
  - LB and LH sign-extend.
  - LBU and LHU zero-extend.
  - LW takes the full word.
- FSM IDLE:
  - Non-memory or misaligned instruction: on the edge, alu_out4<=alu_in4 and inst_out4<=inst_in4 (latency 1); lmd_out4 holds.
  - Aligned memory op: on the edge, latch the access (addr, wdata, be, we = store & mem_wr_en4, opcode, a[1:0], inst, alu), set dmem_req<=1, and go to WAIT. inst_out4<=0 (bubble).
  - A store with mem_wr_en4=0 still performs a write-less request with we=0.
- FSM WAIT:
  - dmem_req, dmem_we, dmem_addr, dmem_wdata and dmem_be are held constant.
  - inst_out4 stays 0 every waiting cycle.
  - On an edge with dmem_ack=1: dmem_req<=0, dmem_we<=0; alu_out4, inst_out4 and lmd_out4 (loads only) update from the latched values; go to IDLE.
  - dmem_ack in IDLE is ignored.
- stall4 = (IDLE & aligned mem op) | (WAIT & ~dmem_ack).
  - Upstream advances on the ack cycle, so back-to-back memory ops cost a minimum of 2 cycles each.
- Back-to-back: in the cycle after an ack, IDLE evaluates the new instruction normally.

Optional Feature:
- Macro DMEM_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each cycle with no ack.
  - When the count reaches TIMEOUT_CYCLES: dmem_req<=0, dmem_err pulses 1 cycle, inst_out4<=latched inst, lmd_out4<=0, go to IDLE. stall4 is low in that cycle.
  - An ack arriving in the same cycle as the timeout wins; no error is raised.
- Undefined: WAIT has no limit, and the dmem_err port and counter are absent.

Test Plan:
- Reset: assert reset4 during WAIT with req=1 -> next edge req=0, all outputs 0, a later ack produces no output change.
- SB addr=0x00000102, bin4=0x000000A5 -> be=0100, wdata=0xA5A5A5A5, addr=0x00000100, we=1, stall4 high until the ack cycle, inst_out4 = SB after the ack edge.
- LB addr=0x00000013, rdata=0x80FF7F01, ack 3 cycles after req -> lmd_out4=0xFFFFFF80, stall4 high for 4 cycles. LBU at the same address -> 0x00000080.
- LH addr=0x00000006, rdata=0x8001_1234 -> lmd_out4=0xFFFF8001. LHU -> 0x00008001.
- SW addr=0x00000005 -> no req, misalign_err pulses 1 cycle, inst passes with latency 1, no stall.
- DMEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, LW with no ack -> req drops after 4 wait cycles, dmem_err=1 for one cycle, lmd_out4=0, the next ADDI passes normally.

Source files
------------

// File: rtl/memaccess_stage.sv
// DLX MEM stage: req/ack data-memory port, byte-lane steering for stores, load extraction.
// Optional wait-state limit with dmem_err output is enabled by defining DMEM_TIMEOUT_EN.
module memaccess_stage #(
  parameter int DATA_W = 32
`ifdef DMEM_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 15
`endif
) (
  input  logic              clock4,
  input  logic              reset4,
  input  logic [DATA_W-1:0] alu_in4,
  input  logic [DATA_W-1:0] bin4,
  input  logic [DATA_W-1:0] inst_in4,
  input  logic              mem_wr_en4,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic [3:0]        dmem_be,
  output logic [DATA_W-1:0] alu_out4,
  output logic [DATA_W-1:0] lmd_out4,
  output logic [DATA_W-1:0] inst_out4,
  output logic              stall4,
  output logic              misalign_err
`ifdef DMEM_TIMEOUT_EN
  , output logic            dmem_err
`endif
);

  localparam logic [5:0] OP_LB  = 6'b000001;
  localparam logic [5:0] OP_LBU = 6'b000010;
  localparam logic [5:0] OP_LH  = 6'b000011;
  localparam logic [5:0] OP_LHU = 6'b000100;
  localparam logic [5:0] OP_LW  = 6'b000101;
  localparam logic [5:0] OP_SB  = 6'b001000;
  localparam logic [5:0] OP_SH  = 6'b001001;
  localparam logic [5:0] OP_SW  = 6'b001010;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_WAIT = 1'b1} state_e;

  function automatic logic is_load(input logic [5:0] op);
    case (op)
      OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW: is_load = 1'b1;
      default:                             is_load = 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    case (op)
      OP_SB, OP_SH, OP_SW: is_store = 1'b1;
      default:             is_store = 1'b0;
    endcase
  endfunction

  function automatic logic is_aligned(input logic [5:0] op, input logic [1:0] a);
    case (op)
      OP_LH, OP_LHU, OP_SH: is_aligned = ~a[0];
      OP_LW, OP_SW:         is_aligned = (a == 2'b00);
      default:              is_aligned = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input logic [5:0] op, input logic [1:0] a);
    case (op)
      OP_SB:   lane_be = 4'b0001 << a;
      OP_SH:   lane_be = 4'b0011 << {a[1], 1'b0};
      OP_SW:   lane_be = 4'b1111;
      OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW: lane_be = 4'b1111;
      default: lane_be = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [5:0] op, input logic [31:0] d);
    case (op)
      OP_SB:   lane_wdata = {4{d[7:0]}};
      OP_SH:   lane_wdata = {2{d[15:0]}};
      OP_SW:   lane_wdata = d;
      default: lane_wdata = 32'h0000_0000;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [5:0] op, input logic [1:0] a,
                                           input logic [31:0] rd);
    logic [7:0]  b_v;
    logic [15:0] h_v;
    b_v = 8'(rd >> {a, 3'b000});
    h_v = 16'(rd >> {a[1], 4'b0000});
    case (op)
      OP_LB:   load_ext = {{24{b_v[7]}}, b_v};
      OP_LBU:  load_ext = {24'h00_0000, b_v};
      OP_LH:   load_ext = {{16{h_v[15]}}, h_v};
      OP_LHU:  load_ext = {16'h0000, h_v};
      default: load_ext = rd;
    endcase
  endfunction

  state_e      state_q;
  logic        req_q, we_q, mis_q;
  logic [31:0] addr_q, wdata_q, alu_out_q, lmd_q, inst_out_q;
  logic [3:0]  be_q;
  logic [5:0]  op_lat_q;
  logic [1:0]  off_q;
  logic [31:0] inst_lat_q, alu_lat_q;

  logic [5:0]  op_in;
  logic        mem_op, aligned_op, mem_go, mis_go, timeout_hit;

  assign op_in      = inst_in4[31:26];
  assign mem_op     = is_load(op_in) | is_store(op_in);
  assign aligned_op = is_aligned(op_in, alu_in4[1:0]);
  assign mem_go     = mem_op & aligned_op;
  assign mis_go     = mem_op & ~aligned_op;

`ifdef DMEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
  // Timeout fires on the last permitted wait cycle unless the ack arrives in it.
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) & ~dmem_ack;
  assign dmem_err    = err_q;
`else
  assign timeout_hit = 1'b0;
`endif

  assign stall4 = ((state_q == S_IDLE) & mem_go) |
                  ((state_q == S_WAIT) & ~dmem_ack & ~timeout_hit);

  // Stage FSM: issues the access, holds the port during wait states, retires on ack or timeout.
  always_ff @(posedge clock4) begin
    if (reset4) begin
      state_q    <= S_IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      mis_q      <= 1'b0;
      addr_q     <= 32'h0000_0000;
      wdata_q    <= 32'h0000_0000;
      be_q       <= 4'b0000;
      alu_out_q  <= 32'h0000_0000;
      lmd_q      <= 32'h0000_0000;
      inst_out_q <= 32'h0000_0000;
      op_lat_q   <= 6'b000000;
      off_q      <= 2'b00;
      inst_lat_q <= 32'h0000_0000;
      alu_lat_q  <= 32'h0000_0000;
`ifdef DMEM_TIMEOUT_EN
      cnt_q      <= {CNT_W{1'b0}};
      err_q      <= 1'b0;
`endif
    end else begin
      mis_q <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
      err_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (mem_go) begin
            req_q      <= 1'b1;
            we_q       <= is_store(op_in) & mem_wr_en4;
            addr_q     <= {alu_in4[31:2], 2'b00};
            wdata_q    <= lane_wdata(op_in, bin4);
            be_q       <= lane_be(op_in, alu_in4[1:0]);
            op_lat_q   <= op_in;
            off_q      <= alu_in4[1:0];
            inst_lat_q <= inst_in4;
            alu_lat_q  <= alu_in4;
            inst_out_q <= 32'h0000_0000;
            state_q    <= S_WAIT;
`ifdef DMEM_TIMEOUT_EN
            cnt_q      <= {CNT_W{1'b0}};
`endif
          end else begin
            alu_out_q  <= alu_in4;
            inst_out_q <= inst_in4;
            if (mis_go) begin
              mis_q <= 1'b1;
              lmd_q <= 32'h0000_0000;
            end
          end
        end
        S_WAIT: begin
          if (dmem_ack) begin
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            alu_out_q  <= alu_lat_q;
            inst_out_q <= inst_lat_q;
            if (is_load(op_lat_q)) begin
              lmd_q <= load_ext(op_lat_q, off_q, dmem_rdata);
            end
            state_q    <= S_IDLE;
          end
`ifdef DMEM_TIMEOUT_EN
          else if (timeout_hit) begin
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            err_q      <= 1'b1;
            alu_out_q  <= alu_lat_q;
            inst_out_q <= inst_lat_q;
            lmd_q      <= 32'h0000_0000;
            state_q    <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dmem_req     = req_q;
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_wdata   = wdata_q;
  assign dmem_be      = be_q;
  assign alu_out4     = alu_out_q;
  assign lmd_out4     = lmd_q;
  assign inst_out4    = inst_out_q;
  assign misalign_err = mis_q;

endmodule

// File: tb/tb_memaccess_stage.sv
// Self-checking bench for memaccess_stage: directed vector table, reset/timeout sequences,
// and randomized transactions checked against a transaction-level reference model.
module tb_memaccess_stage;

  logic        clk;
  logic        rst;
  logic [31:0] alu_in, bin_in, inst_in, rdata;
  logic        wen_in, ack;
  logic        req, we, stall, mis;
  logic [31:0] addr, wdata, alu_out, lmd_out, inst_out;
  logic [3:0]  be;
`ifdef DMEM_TIMEOUT_EN
  logic        err;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] lmd_track;

  memaccess_stage #(
    .DATA_W(32)
`ifdef DMEM_TIMEOUT_EN
    , .TIMEOUT_CYCLES(4)
`endif
  ) dut (
    .clock4(clk), .reset4(rst), .alu_in4(alu_in), .bin4(bin_in), .inst_in4(inst_in),
    .mem_wr_en4(wen_in), .dmem_rdata(rdata), .dmem_ack(ack), .dmem_req(req), .dmem_we(we),
    .dmem_addr(addr), .dmem_wdata(wdata), .dmem_be(be), .alu_out4(alu_out),
    .lmd_out4(lmd_out), .inst_out4(inst_out), .stall4(stall), .misalign_err(mis)
`ifdef DMEM_TIMEOUT_EN
    , .dmem_err(err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: kind 0 = no access, 1 = load, 2 = store.
  task automatic model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] rd, output logic [1:0] kind, output logic misal,
                       output logic [3:0] exp_be, output logic [31:0] exp_wd,
                       output logic [31:0] exp_lmd);
    int size, off;
    logic sgn, load;
    logic [31:0] v;
    size = 0; sgn = 1'b0; load = 1'b0;
    case (op)
      6'b000001: begin load = 1'b1; size = 1; sgn = 1'b1; end
      6'b000010: begin load = 1'b1; size = 1; end
      6'b000011: begin load = 1'b1; size = 2; sgn = 1'b1; end
      6'b000100: begin load = 1'b1; size = 2; end
      6'b000101: begin load = 1'b1; size = 4; end
      6'b001000: size = 1;
      6'b001001: size = 2;
      6'b001010: size = 4;
      default:   size = 0;
    endcase
    off    = int'(a % 32'd4);
    misal  = (size != 0) && ((off % size) != 0);
    kind   = (size == 0 || misal) ? 2'd0 : (load ? 2'd1 : 2'd2);
    exp_be = load ? 4'hF : 4'(((1 << size) - 1) << off);
    exp_wd = (size == 1) ? (d & 32'hFF) * 32'h0101_0101 :
             (size == 2) ? (d & 32'hFFFF) * 32'h0001_0001 : d;
    v = rd >> (8 * off);
    if (size < 4) begin
      v = v & ((32'd1 << (8 * size)) - 32'd1);
      if (sgn && v >= (32'd1 << (8 * size - 1))) v = v - (32'd1 << (8 * size));
    end
    exp_lmd = v;
  endtask

  // Run one instruction through the stage; memory acks after dly wait cycles.
  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d,
                       input logic w, input int dly, input logic [31:0] rd,
                       input logic [1:0] kind, input logic misal, input logic [3:0] exp_be,
                       input logic [31:0] exp_wd, input logic [31:0] exp_lmd);
    logic [31:0] inst;
    inst    = {op, 26'($urandom)};
    alu_in  = a; bin_in = d; inst_in = inst; wen_in = w; ack = 1'b0;
    @(negedge clk);
    chk("stall_at_issue", 32'(stall), 32'(kind != 2'd0));
    @(posedge clk); #1;
    if (kind == 2'd0) begin
      if (misal) lmd_track = 32'h0;
      chk("pass_req", 32'(req), 32'h0);
      chk("pass_alu", alu_out, a);
      chk("pass_inst", inst_out, inst);
      chk("pass_misalign", 32'(mis), 32'(misal));
      chk("pass_lmd", lmd_out, lmd_track);
    end else begin
      chk("req_rise", 32'(req), 32'h1);
      chk("req_addr", addr, {a[31:2], 2'b00});
      chk("req_be", 32'(be), 32'(exp_be));
      chk("req_we", 32'(we), 32'((kind == 2'd2) && w));
      if (kind == 2'd2) chk("req_wdata", wdata, exp_wd);
      chk("bubble_inst", inst_out, 32'h0);
      chk("no_misalign", 32'(mis), 32'h0);
      for (int i = 0; i < dly; i++) begin
        @(negedge clk);
        chk("wait_stall", 32'(stall), 32'h1);
        chk("wait_req", 32'(req), 32'h1);
        chk("wait_inst", inst_out, 32'h0);
        @(posedge clk); #1;
      end
      ack = 1'b1; rdata = rd;
      @(negedge clk);
      chk("ack_stall", 32'(stall), 32'h0);
      @(posedge clk); #1;
      ack = 1'b0;
      if (kind == 2'd1) lmd_track = exp_lmd;
      chk("done_req", 32'(req), 32'h0);
      chk("done_we", 32'(we), 32'h0);
      chk("done_inst", inst_out, inst);
      chk("done_alu", alu_out, a);
      chk("done_lmd", lmd_out, lmd_track);
    end
  endtask

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a, d, rd;
    logic        w;
    int          dly;
    logic [1:0]  kind;
    logic        misal;
    logic [3:0]  be;
    logic [31:0] wd, lmd;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [1:0]  k;
    logic        m;
    logic [3:0]  b;
    logic [31:0] wd, lm, a, d, rd;
    logic [5:0]  op;
    logic [5:0]  mem_ops[8];

    vecs[0]  = '{6'b001000, 32'h102, 32'hA5,       32'h0,        1'b1, 2, 2'd2, 1'b0, 4'b0100, 32'hA5A5A5A5, 32'h0};
    vecs[1]  = '{6'b000001, 32'h13,  32'h0,        32'h80FF7F01, 1'b0, 3, 2'd1, 1'b0, 4'hF,    32'h0, 32'hFFFFFF80};
    vecs[2]  = '{6'b000010, 32'h13,  32'h0,        32'h80FF7F01, 1'b0, 3, 2'd1, 1'b0, 4'hF,    32'h0, 32'h00000080};
    vecs[3]  = '{6'b000011, 32'h6,   32'h0,        32'h80011234, 1'b0, 1, 2'd1, 1'b0, 4'hF,    32'h0, 32'hFFFF8001};
    vecs[4]  = '{6'b000100, 32'h6,   32'h0,        32'h80011234, 1'b0, 0, 2'd1, 1'b0, 4'hF,    32'h0, 32'h00008001};
    vecs[5]  = '{6'b001010, 32'h5,   32'h11223344, 32'h0,        1'b1, 0, 2'd0, 1'b1, 4'h0,    32'h0, 32'h0};
    vecs[6]  = '{6'b000101, 32'h8,   32'h0,        32'hDEADBEEF, 1'b0, 0, 2'd1, 1'b0, 4'hF,    32'h0, 32'hDEADBEEF};
    vecs[7]  = '{6'b001001, 32'h2,   32'h1234ABCD, 32'h0,        1'b1, 1, 2'd2, 1'b0, 4'b1100, 32'hABCDABCD, 32'h0};
    vecs[8]  = '{6'b001010, 32'h10,  32'h12345678, 32'h0,        1'b0, 2, 2'd2, 1'b0, 4'hF,    32'h12345678, 32'h0};
    vecs[9]  = '{6'b010000, 32'h55,  32'h0,        32'h0,        1'b0, 0, 2'd0, 1'b0, 4'h0,    32'h0, 32'h0};
    vecs[10] = '{6'b000011, 32'h3,   32'h0,        32'h0,        1'b0, 0, 2'd0, 1'b1, 4'h0,    32'h0, 32'h0};
    vecs[11] = '{6'b000001, 32'h21,  32'h0,        32'h00007F00, 1'b0, 1, 2'd1, 1'b0, 4'hF,    32'h0, 32'h0000007F};
    mem_ops = '{6'b000001, 6'b000010, 6'b000011, 6'b000100, 6'b000101, 6'b001000, 6'b001001, 6'b001010};

    rst = 1'b1; alu_in = 32'h0; bin_in = 32'h0; inst_in = 32'h0; wen_in = 1'b0;
    ack = 1'b0; rdata = 32'h0; lmd_track = 32'h0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_req", 32'(req), 32'h0);
    chk("rst_we", 32'(we), 32'h0);
    chk("rst_be", 32'(be), 32'h0);
    chk("rst_addr", addr, 32'h0);
    chk("rst_lmd", lmd_out, 32'h0);
    chk("rst_inst", inst_out, 32'h0);
    rst = 1'b0;

    foreach (vecs[i])
      issue(vecs[i].op, vecs[i].a, vecs[i].d, vecs[i].w, vecs[i].dly, vecs[i].rd,
            vecs[i].kind, vecs[i].misal, vecs[i].be, vecs[i].wd, vecs[i].lmd);

    // Reset in the middle of a wait: request drops and a late ack must be ignored.
    alu_in = 32'h40; inst_in = {6'b000101, 26'h1}; ack = 1'b0;
    @(posedge clk); #1;
    chk("rstw_req_up", 32'(req), 32'h1);
    @(posedge clk); #1;
    rst = 1'b1; alu_in = 32'h0; inst_in = 32'h0;
    @(posedge clk); #1;
    chk("rstw_req", 32'(req), 32'h0);
    chk("rstw_addr", addr, 32'h0);
    chk("rstw_alu", alu_out, 32'h0);
    chk("rstw_inst", inst_out, 32'h0);
    rst = 1'b0; ack = 1'b1; rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    ack = 1'b0;
    chk("late_ack_req", 32'(req), 32'h0);
    chk("late_ack_lmd", lmd_out, 32'h0);
    chk("late_ack_inst", inst_out, 32'h0);
    lmd_track = 32'h0;

    for (int n = 0; n < 200; n++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      op  = (sel < 8) ? mem_ops[sel] : 6'($urandom);
      a   = $urandom;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      d   = $urandom;
      rd  = $urandom;
      model(op, a, d, rd, k, m, b, wd, lm);
      issue(op, a, d, 1'($urandom), int'($urandom_range(0, 3)), rd, k, m, b, wd, lm);
    end

`ifdef DMEM_TIMEOUT_EN
    alu_in = 32'h20; inst_in = {6'b000101, 26'h2}; ack = 1'b0;
    @(negedge clk);
    chk("to_stall_issue", 32'(stall), 32'h1);
    @(posedge clk); #1;
    chk("to_req_up", 32'(req), 32'h1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("to_wait_stall", 32'(stall), 32'h1);
      @(posedge clk); #1;
      chk("to_wait_req", 32'(req), 32'h1);
    end
    @(negedge clk);
    chk("to_last_stall", 32'(stall), 32'h0);
    @(posedge clk); #1;
    chk("to_req_drop", 32'(req), 32'h0);
    chk("to_err", 32'(err), 32'h1);
    chk("to_lmd", lmd_out, 32'h0);
    chk("to_inst", inst_out, {6'b000101, 26'h2});
    alu_in = 32'h77; inst_in = {6'b010000, 26'h123};
    @(negedge clk);
    chk("to_next_stall", 32'(stall), 32'h0);
    @(posedge clk); #1;
    chk("to_err_clear", 32'(err), 32'h0);
    chk("to_next_alu", alu_out, 32'h77);
    chk("to_next_inst", inst_out, {6'b010000, 26'h123});
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
